fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bundle: PC loop, redirect, instruction-memory and decode handshakes.
interface fetch_if;
   logic [31:0] pc;
   logic [31:0] pc_prim;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready;

   modport slave (
      input  pc, branch_valid, branch_target, imem_ack, imem_rdata, dec_ready,
      output pc_prim, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
   );

   modport master (
      output pc, branch_valid, branch_target, imem_ack, imem_rdata, dec_ready,
      input  pc_prim, imem_req, imem_addr, dec_valid, dec_instr, dec_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC stepping, 2-entry decode FIFO, branch flush/drop.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt counters.
//
// state   | meaning
// S_IDLE  | post-reset, PC forced to RESET_PC, no request
// S_FETCH | request at pc while FIFO has room
// S_DROP  | re-issue request stranded by a branch and discard its data
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   fetch_if.slave      bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

   state_t      r_state;
   logic [1:0]  r_count;
   logic        r_wptr;
   logic        r_rptr;
   logic [31:0] r_drop_addr;
   logic [31:0] r_fifo_pc    [2];
   logic [31:0] r_fifo_instr [2];

   logic w_req;
   logic w_branch;
   logic w_push;
   logic w_pop;

   always_comb begin
      w_req = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: w_req = (r_count < 2'd2);
            S_DROP:  w_req = 1'b1;
            default: w_req = 1'b0;
         endcase
      end
   end

   assign w_branch = !reset && bus.branch_valid && (r_state != S_IDLE);
   assign w_push   = (r_state == S_FETCH) && w_req && bus.imem_ack && !bus.branch_valid;
   assign w_pop    = bus.dec_valid && bus.dec_ready;

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = (r_state == S_DROP) ? r_drop_addr : bus.pc;
   assign bus.dec_valid = !reset && (r_count != 2'd0);
   assign bus.dec_instr = r_fifo_instr[r_rptr];
   assign bus.dec_pc    = r_fifo_pc[r_rptr];

   always_comb begin
      if (reset || (r_state == S_IDLE))
         bus.pc_prim = RESET_PC;
      else if (w_branch)
         bus.pc_prim = bus.branch_target;
      else if (w_push)
         bus.pc_prim = bus.pc + PC_STEP;
      else
         bus.pc_prim = bus.pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_count     <= 2'd0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_drop_addr <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               // a branch strands an un-acked request; it must still be completed
               if (w_branch && w_req && !bus.imem_ack) begin
                  r_state     <= S_DROP;
                  r_drop_addr <= bus.pc;
               end
            end
            S_DROP: begin
               if (bus.imem_ack)
                  r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_branch) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
         end else begin
            if (w_push) begin
               r_fifo_pc[r_wptr]    <= bus.pc;
               r_fifo_instr[r_wptr] <= bus.imem_rdata;
               r_wptr               <= ~r_wptr;
            end
            if (w_pop)
               r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (w_push)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (w_branch)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, directed scenarios, random traffic.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   logic clk = 1'b0;
   logic reset;
   fetch_if bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: mode 0 = idle, 1 = fetching, 2 = dropping a stranded request
   int          m_mode = 0;
   logic [63:0] m_q [$];
   logic [31:0] m_drop = 32'h0;
   logic [31:0] pc_reg = RESET_PC;
   logic [31:0] m_fetches = 32'h0;
   logic [31:0] m_flushes = 32'h0;

   logic [31:0] o_prim, o_addr, o_dpc, o_dinstr;
   logic        o_req, o_dv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic ack, input logic raw);
      logic        e_req, e_acc, e_brk, e_dv, ack_d, popped;
      logic [31:0] e_addr, e_prim, rdata;
      @(negedge clk);
      reset             = rst;
      bus.pc            = pc_reg;
      bus.branch_valid  = br;
      bus.branch_target = tgt;
      bus.dec_ready     = rdy;
      e_req  = !rst && ((m_mode == 1 && m_q.size() < 2) || m_mode == 2);
      e_addr = (m_mode == 2) ? m_drop : pc_reg;
      ack_d  = ack && (e_req || raw);
      rdata  = mem_word(e_addr);
      bus.imem_ack   = ack_d;
      bus.imem_rdata = rdata;
      e_brk  = !rst && br && m_mode != 0;
      e_acc  = !rst && m_mode == 1 && e_req && ack_d && !br;
      e_prim = (rst || m_mode == 0) ? RESET_PC :
               e_brk ? tgt : e_acc ? pc_reg + PC_STEP : pc_reg;
      e_dv   = !rst && m_q.size() != 0;
      #1;
      chk("pc_prim", bus.pc_prim, e_prim);
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
      if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
      chk("dec_valid", {31'b0, bus.dec_valid}, {31'b0, e_dv});
      if (e_dv) begin
         chk("dec_pc", bus.dec_pc, m_q[0][63:32]);
         chk("dec_instr", bus.dec_instr, m_q[0][31:0]);
      end
      o_prim = bus.pc_prim; o_req = bus.imem_req; o_addr = bus.imem_addr;
      o_dv = bus.dec_valid; o_dpc = bus.dec_pc; o_dinstr = bus.dec_instr;
      @(posedge clk);
      popped = e_dv && rdy;
      if (rst) begin
         m_mode = 0;
         m_q.delete();
         m_fetches = 32'h0;
         m_flushes = 32'h0;
      end else begin
         if (e_acc) m_fetches = m_fetches + 32'd1;
         if (e_brk) m_flushes = m_flushes + 32'd1;
         case (m_mode)
            0: m_mode = 1;
            1: begin
               if (e_brk) begin
                  m_q.delete();
                  if (e_req && !ack_d) begin
                     m_mode = 2;
                     m_drop = pc_reg;
                  end
               end else begin
                  if (popped) void'(m_q.pop_front());
                  if (e_acc) m_q.push_back({pc_reg, rdata});
               end
            end
            default: begin
               if (e_brk) m_q.delete();
               else if (popped) void'(m_q.pop_front());
               if (ack_d) m_mode = 1;
            end
         endcase
      end
      pc_reg = e_prim;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk(nm, act, exp);
   endtask

   initial begin
      logic [31:0] tgt;
      reset = 1'b1;
      bus.pc = RESET_PC; bus.branch_valid = 1'b0; bus.branch_target = 32'h0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.dec_ready = 1'b0;

      // streaming with ack and ready every cycle
      step(1, 0, 0, 1, 1, 0); step(1, 0, 0, 1, 1, 0);
      lit("rst_req", {31'b0, o_req}, 32'd0);
      lit("rst_dv", {31'b0, o_dv}, 32'd0);
      step(0, 0, 0, 1, 1, 0); lit("s_prim0", o_prim, 32'h0);
      step(0, 0, 0, 1, 1, 0); lit("s_prim4", o_prim, 32'h4);
      step(0, 0, 0, 1, 1, 0); lit("s_prim8", o_prim, 32'h8);
      lit("s_dpc0", o_dpc, 32'h0); lit("s_din0", o_dinstr, mem_word(32'h0));
      step(0, 0, 0, 1, 1, 0); lit("s_primC", o_prim, 32'hC); lit("s_dpc4", o_dpc, 32'h4);
      step(0, 0, 0, 1, 1, 0); lit("s_dpc8", o_dpc, 32'h8);

      // decode stalled: FIFO fills, request drops, PC holds
      step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      lit("full_req", {31'b0, o_req}, 32'd0); lit("full_prim", o_prim, 32'h8);
      lit("full_dpc", o_dpc, 32'h0);
      step(0, 0, 0, 0, 1, 0); lit("full_prim2", o_prim, 32'h8);
      step(0, 0, 0, 1, 1, 0); lit("pop_prim", o_prim, 32'h8);

      // branch with request at 8 pending
      step(0, 1, 32'h100, 0, 0, 0);
      lit("br_prim", o_prim, 32'h100); lit("br_addr", o_addr, 32'h8);
      step(0, 0, 0, 1, 0, 0);
      lit("drop_req", {31'b0, o_req}, 32'd1); lit("drop_addr", o_addr, 32'h8);
      lit("drop_dv", {31'b0, o_dv}, 32'd0);
      step(0, 0, 0, 1, 1, 0); lit("drop_addr2", o_addr, 32'h8);

      // branch coincident with ack
      step(0, 1, 32'h40, 1, 1, 0);
      lit("bra_addr", o_addr, 32'h100); lit("bra_prim", o_prim, 32'h40);
      step(0, 0, 0, 1, 1, 0);
      lit("bra_dv", {31'b0, o_dv}, 32'd0); lit("bra_addr2", o_addr, 32'h40);
      step(0, 0, 0, 1, 0, 0); lit("bra_dpc", o_dpc, 32'h40);

      // reset during pending request, then a late ack
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 1);
      lit("mrst_req", {31'b0, o_req}, 32'd0); lit("mrst_dv", {31'b0, o_dv}, 32'd0);
      step(0, 0, 0, 1, 1, 1);
      lit("late_prim", o_prim, RESET_PC); lit("late_dv", {31'b0, o_dv}, 32'd0);
      step(0, 0, 0, 1, 1, 0); lit("restart_addr", o_addr, RESET_PC);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tgt = $urandom & 32'hFFFF_FFFC;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, tgt,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0);
`ifdef FETCH_PERF_EN
         if (i % 100 == 99) begin
            #2;
            chk("perf_fetch", perf_fetch_cnt, m_fetches);
            chk("perf_flush", perf_flush_cnt, m_flushes);
         end
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
